rdout_train_ctrl: RTL and testbench
===================================

// Module: rdout_train_ctrl
// PURPOSE
//  Sequences online training of the ESN readout. Counts reservoir washout
//  samples, then enables the readout (rd_ce) and drives the true-output ROM
//  address (rd_addr) in phase with XSTATE. Repeats over N_EPOCHS passes of
//  the training set, then drains the readout pipeline and freezes W_out.
// PARAMETERS
//  ADDR_W     6   width of rd_addr (training-set ROM address)
//  N_SAMPLES  64  samples per epoch (2..2**ADDR_W)
//  WASHOUT    8   x_valid strobes discarded before training (0 allowed)
//  N_EPOCHS   4   training passes (1..2**EP_W-1)
//  EP_W       8   width of epoch counter
//  DRAIN_CYC  4   cycles rd_ce stays high after last sample (readout loop latency)
// PORTS
//  clk       in   1       system clock
//  rst_N     in   1       asynchronous active-low reset
//  start     in   1       1-cycle pulse: begin run (accepted in IDLE or DONE only)
//  abort     in   1       synchronous abort, any state -> IDLE
//  x_valid   in   1       1-cycle strobe: new XSTATE presented this cycle
//  rd_ce     out  1       readout clock enable (ce of readout top)
//  rd_addr   out  ADDR_W  ROM address, index of XSTATE currently presented
//  epoch     out  EP_W    epochs completed in this run
//  busy      out  1       high in WASH, TRAIN, DRAIN
//  done      out  1       high in DONE (sticky until start/abort)
//  wout_lock out  1       1-cycle pulse on DRAIN->DONE (W_out final)
// BEHAVIOUR
//  Reset: state=IDLE; rd_ce=0, rd_addr=0, epoch=0, busy=0, done=0, wout_lock=0.
//  All outputs registered; state changes visible the cycle after the cause.
//  States: IDLE, WASH, TRAIN, DRAIN, DONE (binary encoded, 3 bits).
//  IDLE: start -> WASH (or TRAIN if WASHOUT==0); wash_cnt, rd_addr, epoch cleared.
//  WASH: rd_ce=0. Each x_valid increments wash_cnt; on the WASHOUT-th
//   strobe -> TRAIN. rd_addr held 0.
//  TRAIN: rd_ce=1. rd_addr changes only on x_valid: rd_addr<=rd_addr+1;
//   at rd_addr==N_SAMPLES-1 wraps to 0 and epoch<=epoch+1. Upstream
//   guarantees x_valid precedes the matching XSTATE edge by one cycle.
//   If that strobe completes epoch N_EPOCHS: -> DRAIN, rd_addr held at
//   N_SAMPLES-1 (no wrap), epoch=N_EPOCHS.
//  DRAIN: rd_ce=1, x_valid ignored; counts DRAIN_CYC cycles, then -> DONE
//   with wout_lock pulsed for exactly one cycle.
//  DONE: rd_ce=0, done=1, rd_addr/epoch hold. start -> WASH with counters
//   cleared (new run); the readout keeps its last weights.
//  abort: highest priority in every state; next cycle IDLE, rd_ce=0,
//   rd_addr=0, epoch=0, done=0; no wout_lock. abort+start same cycle: abort wins.
//  start outside IDLE/DONE ignored. x_valid in IDLE/DONE ignored.
//  x_valid on consecutive cycles legal; each strobe counted once.
//  rst_N low mid-run: immediate return to reset values, no pulse generated.
//  Counters never exceed their terminal value; no arithmetic overflow paths.
// TESTING
//  T1 reset: assert rst_N=0 mid-TRAIN -> all outputs 0 same edge-free instant.
//  T2 nominal (defaults, x_valid every 4 cyc): start -> 8 strobes rd_ce=0,
//     then rd_addr 0..63 x4 epochs, epoch 0->4, DRAIN 4 cyc, wout_lock 1 cyc, done=1.
//  T3 WASHOUT=0, N_SAMPLES=2, N_EPOCHS=1: start -> TRAIN directly; 2nd strobe
//     -> DRAIN, rd_addr=1, epoch=1; done after 4 cycles.
//  T4 abort in DRAIN cycle 2 -> IDLE next cycle, rd_ce=0, no wout_lock, done=0.
//  T5 start during TRAIN ignored (rd_addr continues); start in DONE restarts
//     WASH with epoch=0, rd_addr=0; abort+start same cycle -> IDLE.
//  T6 back-to-back x_valid (every cycle) across wrap 63->0 -> epoch
//     increments once, no skipped or repeated address.

Source files
------------

// File: rtl/rdout_train_ctrl_if.sv
// Control/status bundle between the training sequencer and its host.
// The master side drives run control and sample strobes; the slave is the sequencer.
interface rdout_train_ctrl_if #(
    parameter int ADDR_W = 6,
    parameter int EP_W   = 8
);
    logic              start;
    logic              abort;
    logic              x_valid;
    logic              rd_ce;
    logic [ADDR_W-1:0] rd_addr;
    logic [EP_W-1:0]   epoch;
    logic              busy;
    logic              done;
    logic              wout_lock;

    modport master (
        output start, abort, x_valid,
        input  rd_ce, rd_addr, epoch, busy, done, wout_lock
    );

    modport slave (
        input  start, abort, x_valid,
        output rd_ce, rd_addr, epoch, busy, done, wout_lock
    );
endinterface

// File: rtl/rdout_train_ctrl.sv
// ESN readout training sequencer: washout, N_EPOCHS passes over the training
// set with rd_addr tracking XSTATE, pipeline drain, then W_out lock.
module rdout_train_ctrl #(
    parameter int ADDR_W    = 6,
    parameter int N_SAMPLES = 64,
    parameter int WASHOUT   = 8,
    parameter int N_EPOCHS  = 4,
    parameter int EP_W      = 8,
    parameter int DRAIN_CYC = 4
) (
    input  logic                clk,
    input  logic                rst_N,
    rdout_train_ctrl_if.slave   bus
);
    localparam int WC_W = (WASHOUT > 1) ? $clog2(WASHOUT) : 1;
    localparam int DC_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;
    localparam logic [WC_W-1:0]   WASH_LAST  = WC_W'(WASHOUT - 1);
    localparam logic [DC_W-1:0]   DRAIN_LAST = DC_W'(DRAIN_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(N_SAMPLES - 1);
    localparam logic [EP_W-1:0]   EP_LAST    = EP_W'(N_EPOCHS - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WASH  = 3'd1,
        TRAIN = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t            state, state_d;
    logic [WC_W-1:0]   wash_cnt, wash_d;
    logic [DC_W-1:0]   drain_cnt, drain_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [EP_W-1:0]   ep_q, ep_d;
    logic              ce_q, ce_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              lock_q, lock_d;

    always_ff @(posedge clk or negedge rst_N) begin
        if (!rst_N) begin
            state     <= IDLE;
            wash_cnt  <= '0;
            drain_cnt <= '0;
            addr_q    <= '0;
            ep_q      <= '0;
            ce_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            lock_q    <= 1'b0;
        end else begin
            state     <= state_d;
            wash_cnt  <= wash_d;
            drain_cnt <= drain_d;
            addr_q    <= addr_d;
            ep_q      <= ep_d;
            ce_q      <= ce_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            lock_q    <= lock_d;
        end
    end

    always_comb begin
        state_d = state;
        wash_d  = wash_cnt;
        drain_d = drain_cnt;
        addr_d  = addr_q;
        ep_d    = ep_q;
        lock_d  = 1'b0;

        if (bus.abort) begin
            state_d = IDLE;
            wash_d  = '0;
            drain_d = '0;
            addr_d  = '0;
            ep_d    = '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        wash_d  = '0;
                        drain_d = '0;
                        addr_d  = '0;
                        ep_d    = '0;
                        state_d = (WASHOUT == 0) ? TRAIN : WASH;
                    end
                end
                WASH: begin
                    if (bus.x_valid) begin
                        if (wash_cnt == WASH_LAST) begin
                            wash_d  = '0;
                            state_d = TRAIN;
                        end else begin
                            wash_d = wash_cnt + 1'b1;
                        end
                    end
                end
                TRAIN: begin
                    if (bus.x_valid) begin
                        if (addr_q == ADDR_LAST) begin
                            ep_d = ep_q + 1'b1;
                            // Final epoch keeps the last address for the drain window.
                            if (ep_q == EP_LAST) begin
                                drain_d = '0;
                                state_d = DRAIN;
                            end else begin
                                addr_d = '0;
                            end
                        end else begin
                            addr_d = addr_q + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRAIN_LAST) begin
                        state_d = DONE;
                        lock_d  = 1'b1;
                    end else begin
                        drain_d = drain_cnt + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        ce_d   = (state_d == TRAIN) || (state_d == DRAIN);
        busy_d = (state_d == WASH) || (state_d == TRAIN) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

    assign bus.rd_ce     = ce_q;
    assign bus.rd_addr   = addr_q;
    assign bus.epoch     = ep_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.wout_lock = lock_q;
endmodule

// File: tb/tb_rdout_train_ctrl.sv
// Directed bench for rdout_train_ctrl: default build plus a short
// (no washout, 2 samples, 1 epoch) build; address/epoch via scoreboard.
module tb_rdout_train_ctrl;
    logic clk   = 1'b0;
    logic rst_N = 1'b0;
    always #5 clk = ~clk;

    rdout_train_ctrl_if #(.ADDR_W(6), .EP_W(8)) b ();
    rdout_train_ctrl_if #(.ADDR_W(6), .EP_W(8)) s ();

    rdout_train_ctrl #(.ADDR_W(6), .N_SAMPLES(64), .WASHOUT(8), .N_EPOCHS(4),
                       .EP_W(8), .DRAIN_CYC(4)) dut (
        .clk(clk), .rst_N(rst_N), .bus(b)
    );

    rdout_train_ctrl #(.ADDR_W(6), .N_SAMPLES(2), .WASHOUT(0), .N_EPOCHS(1),
                       .EP_W(8), .DRAIN_CYC(4)) dut_s (
        .clk(clk), .rst_N(rst_N), .bus(s)
    );

    typedef struct packed {
        logic [5:0] a;
        logic [7:0] e;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0;
    int         errors = 0;
    logic [5:0] ea;
    logic [7:0] ee;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic outs(input string tag, input bit sel, input logic ce, input logic [5:0] a,
                        input logic [7:0] e, input logic bz, input logic dn, input logic lk);
        chk({tag, ".rd_ce"},     32'(sel ? s.rd_ce     : b.rd_ce),     32'(ce));
        chk({tag, ".rd_addr"},   32'(sel ? s.rd_addr   : b.rd_addr),   32'(a));
        chk({tag, ".epoch"},     32'(sel ? s.epoch     : b.epoch),     32'(e));
        chk({tag, ".busy"},      32'(sel ? s.busy      : b.busy),      32'(bz));
        chk({tag, ".done"},      32'(sel ? s.done      : b.done),      32'(dn));
        chk({tag, ".wout_lock"}, 32'(sel ? s.wout_lock : b.wout_lock), 32'(lk));
    endtask

    // Expected address/epoch after one strobe in TRAIN, per the default build.
    task automatic train_strobe(input int gap);
        exp_t x;
        if (ea == 6'd63) begin
            if (ee == 8'd3) ee = 8'd4;
            else begin ea = 6'd0; ee = ee + 8'd1; end
        end else begin
            ea = ea + 6'd1;
        end
        sb.push_back({ea, ee});
        b.x_valid = 1'b1;
        tick();
        b.x_valid = 1'b0;
        if (sb.size() == 0) begin
            chk("sb.underflow", 32'd0, 32'd1);
        end else begin
            x = sb.pop_front();
            chk("train.rd_addr", 32'(b.rd_addr), 32'(x.a));
            chk("train.epoch",   32'(b.epoch),   32'(x.e));
            chk("train.rd_ce",   32'(b.rd_ce),   32'd1);
        end
        repeat (gap) tick();
    endtask

    task automatic wash_all(input int gap);
        for (int i = 0; i < 8; i++) begin
            b.x_valid = 1'b1;
            tick();
            b.x_valid = 1'b0;
            if (i < 7) begin
                chk("wash.rd_ce", 32'(b.rd_ce), 32'd0);
                chk("wash.busy",  32'(b.busy),  32'd1);
            end else begin
                chk("wash.to_train", 32'(b.rd_ce), 32'd1);
                chk("wash.addr0",    32'(b.rd_addr), 32'd0);
            end
            repeat (gap) tick();
        end
        ea = '0;
        ee = '0;
    endtask

    task automatic wait_lock(input bit sel, input int exp_cyc, input string tag);
        int  n;
        bit  found;
        n = 0;
        found = 1'b0;
        while (n < 20 && !found) begin
            tick();
            n++;
            if (sel ? s.wout_lock : b.wout_lock) found = 1'b1;
        end
        chk({tag, ".lock_seen"},   32'(found), 32'd1);
        chk({tag, ".drain_cycles"}, 32'(n),    32'(exp_cyc));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "simulation timeout");
    end

    initial begin
        int lock_seen;
        b.start = 0; b.abort = 0; b.x_valid = 0;
        s.start = 0; s.abort = 0; s.x_valid = 0;
        ea = '0; ee = '0;

        #1;
        outs("reset", 1'b0, 0, 0, 0, 0, 0, 0);
        outs("reset_s", 1'b1, 0, 0, 0, 0, 0, 0);
        tick();
        tick();
        rst_N = 1'b1;
        tick();
        outs("idle", 1'b0, 0, 0, 0, 0, 0, 0);

        // T2: nominal run, strobes every 4 cycles
        b.start = 1'b1; tick(); b.start = 1'b0;
        outs("t2.wash", 1'b0, 0, 0, 0, 1, 0, 0);
        wash_all(3);
        for (int i = 0; i < 256; i++) train_strobe(i == 255 ? 0 : 3);
        outs("t2.drain", 1'b0, 1, 63, 4, 1, 0, 0);
        wait_lock(1'b0, 4, "t2");
        outs("t2.lock", 1'b0, 0, 63, 4, 0, 1, 1);
        tick();
        outs("t2.done", 1'b0, 0, 63, 4, 0, 1, 0);
        b.x_valid = 1'b1; tick(); b.x_valid = 1'b0;
        outs("t2.done_xv", 1'b0, 0, 63, 4, 0, 1, 0);

        // T5: restart from DONE, start ignored in TRAIN
        b.start = 1'b1; tick(); b.start = 1'b0;
        outs("t5.restart", 1'b0, 0, 0, 0, 1, 0, 0);
        wash_all(0);
        repeat (5) train_strobe(1);
        b.start = 1'b1; tick(); b.start = 1'b0;
        outs("t5.start_in_train", 1'b0, 1, 5, 0, 1, 0, 0);

        // T6: back-to-back strobes across the 63->0 wrap
        repeat (70) train_strobe(0);
        chk("t6.epoch", 32'(b.epoch), 32'd1);
        chk("t6.addr", 32'(b.rd_addr), 32'd11);
        chk("t6.sb_empty", 32'(sb.size()), 32'd0);

        // abort and start together
        b.abort = 1'b1; b.start = 1'b1; tick(); b.abort = 1'b0; b.start = 1'b0;
        outs("t5.abort_start", 1'b0, 0, 0, 0, 0, 0, 0);
        tick();
        outs("t5.stay_idle", 1'b0, 0, 0, 0, 0, 0, 0);

        // T1: asynchronous reset in the middle of TRAIN
        b.start = 1'b1; tick(); b.start = 1'b0;
        wash_all(0);
        repeat (3) train_strobe(1);
        #2;
        rst_N = 1'b0;
        #1;
        outs("t1.async_rst", 1'b0, 0, 0, 0, 0, 0, 0);
        tick();
        rst_N = 1'b1;
        tick();
        outs("t1.after_rst", 1'b0, 0, 0, 0, 0, 0, 0);

        // T3: short build, straight to TRAIN
        s.start = 1'b1; tick(); s.start = 1'b0;
        outs("t3.train", 1'b1, 1, 0, 0, 1, 0, 0);
        s.x_valid = 1'b1; tick(); s.x_valid = 1'b0;
        outs("t3.strobe1", 1'b1, 1, 1, 0, 1, 0, 0);
        s.x_valid = 1'b1; tick(); s.x_valid = 1'b0;
        outs("t3.drain", 1'b1, 1, 1, 1, 1, 0, 0);
        wait_lock(1'b1, 4, "t3");
        outs("t3.lock", 1'b1, 0, 1, 1, 0, 1, 1);
        tick();
        outs("t3.done", 1'b1, 0, 1, 1, 0, 1, 0);

        // T4: abort in the second DRAIN cycle
        s.start = 1'b1; tick(); s.start = 1'b0;
        outs("t4.train", 1'b1, 1, 0, 0, 1, 0, 0);
        repeat (2) begin
            s.x_valid = 1'b1; tick(); s.x_valid = 1'b0;
        end
        outs("t4.drain1", 1'b1, 1, 1, 1, 1, 0, 0);
        tick();
        s.abort = 1'b1; tick(); s.abort = 1'b0;
        outs("t4.abort", 1'b1, 0, 0, 0, 0, 0, 0);
        lock_seen = 0;
        repeat (8) begin
            tick();
            if (s.wout_lock || s.done) lock_seen++;
        end
        chk("t4.no_lock", 32'(lock_seen), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
